// File: rtl/key_scanner_pkg.sv
// key_scanner_pkg
//   Shared types and constants for the front-panel keypad scanner.
//   - state_e     : scan FSM states (IDLE, SCAN, GAP)
//   - KEY_*       : key indices for the non-digit keys
//   - lsb_index() : lowest-set-bit encoder used to choose which key is reported
package key_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int KEY_ENTER = 10;
  localparam int KEY_CLOCK = 11;
  localparam int KEY_ALARM = 12;

  // Widest key vector the encoder accepts; callers zero-extend into it.
  localparam int MAX_KEYS = 32;

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic int unsigned lsb_index(input logic [MAX_KEYS-1:0] v);
    lsb_index = 0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lsb_index = i;
    end
  endfunction

endpackage

// File: rtl/key_scanner_if.sv
// key_scanner_if
//   Bundles the keypad scanner's control, key and report signals.
//   master : panel/test side, drives scan_en and keys
//   slave  : scanner side, drives signal, slot_idx, frame_sync, key_valid,
//            key_code and key_held
interface key_scanner_if #(
  parameter int NUM_KEYS = 13
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic                scan_en;
  logic [NUM_KEYS-1:0] keys;
  logic                signal;
  logic [IDX_W-1:0]    slot_idx;
  logic                frame_sync;
  logic                key_valid;
  logic [IDX_W-1:0]    key_code;
  logic [NUM_KEYS-1:0] key_held;

  modport master (
    output scan_en, keys,
    input  signal, slot_idx, frame_sync, key_valid, key_code, key_held
  );

  modport slave (
    input  scan_en, keys,
    output signal, slot_idx, frame_sync, key_valid, key_code, key_held
  );

endinterface

// File: rtl/key_scanner_debounce.sv
// key_debounce
//   Per-key frame debouncer. On each update strobe the frame sample is
//   compared with the debounced level; DEBOUNCE_SCANS consecutive differing
//   samples flip the level, any agreeing sample restarts the count.
//   Ports:
//     clk, reset   : clock, asynchronous active-high reset
//     upd_i        : one-cycle update strobe (end of frame)
//     shadow_i     : key level captured during the frame
//     level_o      : debounced level
//     level_nxt_o  : level the debouncer will hold after this cycle
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic upd_i,
  input  logic shadow_i,
  output logic level_o,
  output logic level_nxt_o
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (upd_i) begin
      if (shadow_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/key_scanner.sv
// key_scanner
//   Front-panel keypad scanner. A free-running slot counter walks NUM_KEYS
//   slots of SLOT_CYCLES cycles followed by FRAME_GAP idle cycles. Each key
//   is driven onto the serial 'signal' line during its slot (minus guard
//   bands), captured into a frame shadow, debounced once per frame, and new
//   presses are reported one per frame, lowest index first.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     bus        : key_scanner_if.slave (scan_en, keys in; signal, slot_idx,
//                  frame_sync, key_valid, key_code, key_held out)
//   Build option:
//     KEY_SCANNER_REPEAT_EN : re-pulse key_valid every REPEAT_FRAMES frames
//                             while the reported key stays the lowest held key.
module key_scanner
  import key_scanner_pkg::*;
#(
  parameter int NUM_KEYS       = 13,
  parameter int SLOT_CYCLES    = 10,
  parameter int GUARD_CYCLES   = 1,
  parameter int FRAME_GAP      = 30,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_FRAMES  = 8
) (
  input  logic         clk,
  input  logic         reset,
  key_scanner_if.slave bus
);

  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_MAX = (SLOT_CYCLES > FRAME_GAP) ? SLOT_CYCLES : FRAME_GAP;
  localparam int CYC_W   = $clog2(CNT_MAX + 1);
  localparam int ACT_LO  = GUARD_CYCLES;
  localparam int ACT_HI  = SLOT_CYCLES - GUARD_CYCLES - 1;

  if (SLOT_CYCLES <= 2 * GUARD_CYCLES || DEBOUNCE_SCANS < 1 ||
      REPEAT_FRAMES < 1 || NUM_KEYS > MAX_KEYS) begin : g_param_check
    $error("key_scanner: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [IDX_W-1:0]    slot_q, slot_d;
  logic                signal_q, signal_d;
  logic [NUM_KEYS-1:0] shadow_q, shadow_d;
  logic [NUM_KEYS-1:0] reported_q, reported_d;
  logic                key_valid_q, key_valid_d;
  logic [IDX_W-1:0]    key_code_q, key_code_d;

  logic [NUM_KEYS-1:0] held, held_nxt, rep_keep, pending;
  logic                slot_last_cyc, scan_last, gap_last, frame_end;

  assign slot_last_cyc = (cyc_q == CYC_W'(SLOT_CYCLES - 1));
  assign scan_last     = (state_q == SCAN) && slot_last_cyc &&
                         (slot_q == IDX_W'(NUM_KEYS - 1));
  assign gap_last      = (state_q == GAP) && (cyc_q == CYC_W'(FRAME_GAP - 1));
  // Without a gap the frame ends on the last cycle of the last slot.
  assign frame_end     = (FRAME_GAP == 0) ? scan_last : gap_last;

  // Slot/cycle sequencing. cyc_q is reused as the gap counter.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        state_d = SCAN;
        cyc_d   = '0;
        slot_d  = '0;
      end
      SCAN: begin
        if (slot_last_cyc) begin
          cyc_d = '0;
          if (slot_q == IDX_W'(NUM_KEYS - 1)) begin
            slot_d  = '0;
            state_d = (FRAME_GAP == 0) ? SCAN : GAP;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = SCAN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping scan_en abandons the partial frame from any state.
    if (!bus.scan_en) begin
      state_d = IDLE;
      cyc_d   = '0;
      slot_d  = '0;
    end
  end

  // 'signal' is registered from the next-cycle position so that it lines up
  // with the cycle count it belongs to.
  always_comb begin
    signal_d = 1'b0;
    if (state_d == SCAN && cyc_d >= CYC_W'(ACT_LO) && cyc_d <= CYC_W'(ACT_HI))
      signal_d = bus.keys[slot_d];
  end

  // Capture each key on the last active cycle of its slot.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == SCAN && cyc_q == CYC_W'(ACT_HI))
      shadow_d[slot_q] = bus.keys[slot_q];
  end

  // Debouncers see shadow_d so a capture in the frame's final cycle counts.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .upd_i      (frame_end),
      .shadow_i   (shadow_d[i]),
      .level_o    (held[i]),
      .level_nxt_o(held_nxt[i])
    );
  end

  // Reports are decided against the post-update debounced state so the
  // key_valid register lands on the cycle after frame_sync.
  assign rep_keep = reported_q & held_nxt;
  assign pending  = held_nxt & ~rep_keep;

`ifdef KEY_SCANNER_REPEAT_EN
  localparam int RPT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  logic [NUM_KEYS-1:0][RPT_W-1:0] rpt_q, rpt_d;
  logic [IDX_W-1:0]               rpt_lo;
`endif

  always_comb begin
    reported_d  = rep_keep;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
`ifdef KEY_SCANNER_REPEAT_EN
    rpt_d  = rpt_q;
    rpt_lo = IDX_W'(lsb_index(MAX_KEYS'(held_nxt)));
    if (frame_end) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!rep_keep[i] || rpt_q[i] == RPT_W'(REPEAT_FRAMES - 1))
          rpt_d[i] = '0;
        else
          rpt_d[i] = rpt_q[i] + 1'b1;
      end
    end
`endif
    if (frame_end && |pending) begin
      key_valid_d = 1'b1;
      key_code_d  = IDX_W'(lsb_index(MAX_KEYS'(pending)));
      reported_d  = rep_keep | (NUM_KEYS'(1) << key_code_d);
`ifdef KEY_SCANNER_REPEAT_EN
      rpt_d[key_code_d] = '0;
    end else if (frame_end && rep_keep[rpt_lo] &&
                 rpt_q[rpt_lo] == RPT_W'(REPEAT_FRAMES - 1)) begin
      // A new press has priority; otherwise only the lowest held key repeats.
      key_valid_d = 1'b1;
      key_code_d  = rpt_lo;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      slot_q      <= '0;
      signal_q    <= 1'b0;
      shadow_q    <= '0;
      reported_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
`ifdef KEY_SCANNER_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      slot_q      <= slot_d;
      signal_q    <= signal_d;
      shadow_q    <= shadow_d;
      reported_q  <= reported_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
`ifdef KEY_SCANNER_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign bus.signal     = signal_q;
  assign bus.slot_idx   = slot_q;
  assign bus.frame_sync = frame_end;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;
  assign bus.key_held   = held;

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner
//   Bench for key_scanner at default parameters: a vector table of press
//   patterns run from reset, plus sequences for scan_en interruption and an
//   asynchronous mid-frame reset followed by release and re-press.
module tb_key_scanner;
  import key_scanner_pkg::*;

  localparam int NK    = 13;
  localparam int SLOT  = 10;
  localparam int FRAME = NK * SLOT + 30;
  localparam int CW    = $clog2(NK);

  logic clk = 1'b0;
  logic reset = 1'b1;

  key_scanner_if #(.NUM_KEYS(NK)) bus ();

  key_scanner dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t0      = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    int cyc;
    int code;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [NK-1:0] keys;
    int            hold;
    int            total;
    logic [NK-1:0] held;
    int            nrep;
    int            code0;
    int            code1;
  } vec_t;
  vec_t tbl[7];

  int sig_err, sig_at, sig_got, sig_want;
  int fs_err, fs_at, fs_got, fs_want;
  int sl_err, sl_at, sl_got, sl_want;
  int rel_f;

  task automatic check(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic check_cnt(input string nm, input int errs, input int at,
                           input int got, input int want);
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: %0d cycles wrong, first at cycle %0d got %0d want %0d",
               nm, errs, at, got, want);
    end
  endtask

  task automatic check_zero(input string nm);
    check(nm, int'({bus.signal, bus.slot_idx, bus.frame_sync, bus.key_valid,
                    bus.key_code, bus.key_held}), 0);
  endtask

  task automatic push(input int c, input int code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    sbq.push_back(e);
  endtask

  task automatic clr_err();
    sig_err = 0; fs_err = 0; sl_err = 0;
  endtask

  task automatic end_case(input string nm);
    chk_en = 1'b0;
    check_cnt({nm, "_signal"}, sig_err, sig_at, sig_got, sig_want);
    check_cnt({nm, "_frame_sync"}, fs_err, fs_at, fs_got, fs_want);
    check_cnt({nm, "_slot_idx"}, sl_err, sl_at, sl_got, sl_want);
    check({nm, "_reports_missing"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic do_reset();
    chk_en      = 1'b0;
    bus.scan_en = 1'b0;
    bus.keys    = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Enables scanning; afterwards the current cycle is frame cycle 0.
  task automatic start(input logic [NK-1:0] k);
    @(negedge clk);
    bus.keys    = k;
    bus.scan_en = 1'b1;
    @(posedge clk);
    #1;
    t0     = tcyc;
    chk_en = 1'b1;
  endtask

  // Advance to just after the edge that begins frame cycle c.
  task automatic goto(input int c);
    while ((tcyc - t0) < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Cycle-by-cycle expectations for the serial line and frame timing.
  int  ck_c, ck_p, ck_sl;
  logic ck_sig, ck_fs;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      ck_c   = tcyc - t0;
      ck_p   = ck_c % FRAME;
      ck_sl  = (ck_p < NK * SLOT) ? ck_p / SLOT : 0;
      ck_sig = (ck_p < NK * SLOT) && (ck_p % SLOT >= 1) &&
               (ck_p % SLOT <= SLOT - 2) && bus.keys[ck_sl];
      ck_fs  = (ck_p == FRAME - 1);
      if (bus.signal !== ck_sig) begin
        if (sig_err == 0) begin
          sig_at = ck_c; sig_got = int'(bus.signal); sig_want = int'(ck_sig);
        end
        sig_err++;
      end
      if (bus.frame_sync !== ck_fs) begin
        if (fs_err == 0) begin
          fs_at = ck_c; fs_got = int'(bus.frame_sync); fs_want = int'(ck_fs);
        end
        fs_err++;
      end
      if (int'(bus.slot_idx) != ck_sl) begin
        if (sl_err == 0) begin
          sl_at = ck_c; sl_got = int'(bus.slot_idx); sl_want = ck_sl;
        end
        sl_err++;
      end
    end
  end

  // Scoreboard: every key_valid pulse must match the next queued report.
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (bus.key_valid === 1'b1) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL key_valid_unexpected: code %0d at cycle %0d, want no report",
                 bus.key_code, tcyc - t0);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.cyc != tcyc || mon_e.code != int'(bus.key_code)) begin
          n_fail++;
          $display("FAIL key_report: got code %0d at cycle %0d, want code %0d at cycle %0d",
                   bus.key_code, tcyc - t0, mon_e.code, mon_e.cyc - t0);
        end
      end
    end
  end

  initial begin
    bus.scan_en = 1'b0;
    bus.keys    = '0;

    //        keys                              hold total held                               nrep c0          c1
    tbl[0] = '{'0,                              3,   3,    '0,                                0,   0,          0};
    tbl[1] = '{NK'(1) << 3,                     4,   4,    NK'(1) << 3,                       1,   3,          0};
    tbl[2] = '{(NK'(1) << 3) | (NK'(1) << 7),   4,   4,    (NK'(1) << 3) | (NK'(1) << 7),     2,   3,          7};
    tbl[3] = '{NK'(1) << 5,                     1,   3,    '0,                                0,   0,          0};
    tbl[4] = '{(NK'(1) << 0) | (NK'(1) << 12),  4,   4,    (NK'(1) << 0) | (NK'(1) << 12),    2,   0,          KEY_ALARM};
    tbl[5] = '{NK'(1) << 3,                     2,   4,    '0,                                1,   3,          0};
    tbl[6] = '{(NK'(1) << KEY_ENTER) | (NK'(1) << KEY_CLOCK), 4, 4,
               (NK'(1) << KEY_ENTER) | (NK'(1) << KEY_CLOCK), 2, KEY_ENTER,  KEY_CLOCK};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      clr_err();
      start(tbl[i].keys);
      if (tbl[i].nrep > 0) push(t0 + 2 * FRAME, tbl[i].code0);
      if (tbl[i].nrep > 1) push(t0 + 3 * FRAME, tbl[i].code1);
      if (tbl[i].hold < tbl[i].total) begin
        goto(tbl[i].hold * FRAME);
        bus.keys = '0;
      end
      goto(tbl[i].total * FRAME + 1);
      check($sformatf("case%0d_key_held", i), int'(bus.key_held), int'(tbl[i].held));
      end_case($sformatf("case%0d", i));
    end

    // scan_en dropped mid-frame: slot restarts, debounce progress survives.
    do_reset();
    clr_err();
    start(NK'(1) << 3);
    goto(200);
    chk_en      = 1'b0;
    bus.scan_en = 1'b0;
    @(posedge clk);
    #2;
    check("drop_idle_slot_idx", int'(bus.slot_idx), 0);
    check("drop_idle_signal", int'(bus.signal), 0);
    check("drop_idle_key_held", int'(bus.key_held), 0);
    @(negedge clk);
    bus.scan_en = 1'b1;
    @(posedge clk);
    #1;
    t0     = tcyc;
    chk_en = 1'b1;
    push(t0 + FRAME, 3);
    goto(2 * FRAME + 1);
    check("drop_key_held", int'(bus.key_held), int'(NK'(1) << 3));
    end_case("drop");

    // Asynchronous reset mid-frame, then release and re-press of key 9.
    do_reset();
    clr_err();
    start(NK'(1) << 9);
    goto(251);
    chk_en = 1'b0;
    check("pre_reset_slot_idx", int'(bus.slot_idx), 9);
    check("pre_reset_signal", int'(bus.signal), 1);
    reset       = 1'b1;
    bus.scan_en = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start(NK'(1) << 9);
    push(t0 + 2 * FRAME, 9);
    rel_f = 3;
`ifdef KEY_SCANNER_REPEAT_EN
    push(t0 + 10 * FRAME, 9);
    rel_f = 11;
`endif
    goto(rel_f * FRAME);
    check("held_before_release", int'(bus.key_held), int'(NK'(1) << 9));
    bus.keys = '0;
    goto((rel_f + 2) * FRAME);
    check("held_after_release", int'(bus.key_held), 0);
    bus.keys = NK'(1) << 9;
    push(t0 + (rel_f + 4) * FRAME, 9);
    goto((rel_f + 4) * FRAME + 2);
    check("held_after_repress", int'(bus.key_held), int'(NK'(1) << 9));
    end_case("reset_repress");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
